// File: rtl/dualmem_param.sv
`default_nettype none
// ============================================================================
//  Module      : dualmem_param
//  Description : Parametrised single-clock true-dual-port RAM with byte-lane
//                write enables, 1- or 2-cycle read latency, selectable
//                same-port read-during-write behaviour, a post-reset
//                zero-fill sequencer and same-address collision detection
//                with a saturating collision counter.
//  Ports       : clk, rst (async, active high)
//                ena/enb, wea/web [NB], addra/addrb, dina/dinb  -- port requests
//                douta/doutb, doutva/doutvb                    -- read results
//                init_done, collision, coll_count[15:0]        -- status
//  Revision    : 1.0  initial release
// ============================================================================
module dualmem_param #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 9,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = DATA_WIDTH / BYTE_WIDTH,
    localparam int DEPTH         = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  enb,
    input  logic [NB-1:0]         wea,
    input  logic [NB-1:0]         web,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] douta,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutva,
    output logic                  doutvb,
    output logic                  init_done,
    output logic                  collision,
    output logic [15:0]           coll_count
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    run_w;
    logic                    clr_w;
    logic                    acc_a_w, acc_b_w;
    logic                    coll_w;
    logic [DATA_WIDTH-1:0]   old_a_w, old_b_w;
    logic [DATA_WIDTH-1:0]   rd_a_w, rd_b_w;

    logic                    v1_a_q, v1_b_q;
    logic [DATA_WIDTH-1:0]   d1_a_q, d1_b_q;
    logic                    coll_q;
    logic [15:0]             cnt_q;

    // ------------------------------------------------------------------
    // Clear / run sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET == 0) begin
                state_d = ST_RUN;
            end else begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (&ptr_q) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign run_w     = (state_q == ST_RUN);
    assign clr_w     = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    assign init_done = run_w;

    // Requests are only honoured once the memory is initialised.
    assign acc_a_w = ena && run_w;
    assign acc_b_w = enb && run_w;

    assign coll_w = acc_a_w && acc_b_w && (addra == addrb) && ((|wea) || (|web));

    // ------------------------------------------------------------------
    // Storage. Port B lanes are applied first so that port A wins any lane
    // written by both ports in the same cycle. Contents are deliberately
    // not reset: only the clear sequence overwrites them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_w) begin
            mem_q[ptr_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (acc_b_w && web[i]) begin
                    mem_q[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (acc_a_w && wea[i]) begin
                    mem_q[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data selection. The array value is pre-write (old data); in
    // write-first mode a port's own written lanes are substituted. The
    // other port's write is never forwarded.
    // ------------------------------------------------------------------
    assign old_a_w = mem_q[addra];
    assign old_b_w = mem_q[addrb];

    always_comb begin
        rd_a_w = old_a_w;
        rd_b_w = old_b_w;
        if (WRITE_FIRST != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    rd_a_w[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (web[i]) begin
                    rd_b_w[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage: data only updates when a read completes, so the
    // output holds its last value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_a_q <= 1'b0;
            v1_b_q <= 1'b0;
            d1_a_q <= '0;
            d1_b_q <= '0;
        end else begin
            v1_a_q <= acc_a_w;
            v1_b_q <= acc_b_w;
            if (acc_a_w) begin
                d1_a_q <= rd_a_w;
            end
            if (acc_b_w) begin
                d1_b_q <= rd_b_w;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  v2_a_q, v2_b_q;
            logic [DATA_WIDTH-1:0] d2_a_q, d2_b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2_a_q <= 1'b0;
                    v2_b_q <= 1'b0;
                    d2_a_q <= '0;
                    d2_b_q <= '0;
                end else begin
                    v2_a_q <= v1_a_q;
                    v2_b_q <= v1_b_q;
                    if (v1_a_q) begin
                        d2_a_q <= d1_a_q;
                    end
                    if (v1_b_q) begin
                        d2_b_q <= d1_b_q;
                    end
                end
            end

            assign douta  = d2_a_q;
            assign doutb  = d2_b_q;
            assign doutva = v2_a_q;
            assign doutvb = v2_b_q;
        end else begin : g_lat1
            assign douta  = d1_a_q;
            assign doutb  = d1_b_q;
            assign doutva = v1_a_q;
            assign doutvb = v1_b_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Collision pulse and saturating counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll_w;
            if (coll_w && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign collision  = coll_q;
    assign coll_count = cnt_q;

endmodule
`default_nettype wire
